// File: rtl/hazard_ctrl.sv
// Hazard unit: operand forwarding selects, load-use/branch stall-flush control and data-cache miss freeze.
// Latency: forwarding and stall/flush are combinational; miss FSM is registered (RUN->REQ->WAIT*->RESUME->RUN).
// Backpressure: a miss stalls every pipeline register until the refill completes; no flushes fire while frozen.
module hazard_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            i_Rs1D,
  input  logic [4:0]            i_Rs2D,
  input  logic [4:0]            i_Rs1E,
  input  logic [4:0]            i_Rs2E,
  input  logic [4:0]            i_RdE,
  input  logic                  i_ResultSrcE0,
  input  logic                  i_PCSrcE,
  input  logic [4:0]            i_RdM,
  input  logic                  i_RegWriteM,
  input  logic [4:0]            i_RdW,
  input  logic                  i_RegWriteW,
  input  logic                  i_CacheMissM,
  input  logic                  i_MemRefillDone,
  output logic [1:0]            o_ForwardAE,
  output logic [1:0]            o_ForwardBE,
  output logic                  o_StallF,
  output logic                  o_StallD,
  output logic                  o_StallE,
  output logic                  o_StallM,
  output logic                  o_FlushD,
  output logic                  o_FlushE,
  output logic                  o_MemReq,
  output logic                  o_RefillTimeout,
  output logic [DATA_WIDTH-1:0] o_StallCycles
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_RESUME = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_wait_cnt;
  logic                  r_timeout;
  logic [DATA_WIDTH-1:0] r_stall_cycles;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_lw_stall;
  logic       w_miss_stall;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_flush_d;
  logic       w_flush_e;
  logic       w_mem_req;

  // M-stage result has priority over W-stage; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Forwarding selects and load-use detection, independent of the miss FSM.
  always_comb begin
    w_fwd_a    = fwd_sel(i_Rs1E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
    w_fwd_b    = fwd_sel(i_Rs2E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
    w_lw_stall = i_ResultSrcE0 && (i_RdE != 5'd0) &&
                 ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
  end

  // Miss FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Miss FSM next state plus stall/flush/request decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_miss_stall = 1'b0;
    w_mem_req    = 1'b0;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_stall_m    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_miss_stall = i_CacheMissM;
        if (i_CacheMissM) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_miss_stall = 1'b1;
        w_mem_req    = 1'b1;
        w_state_nxt  = i_MemRefillDone ? S_RESUME : S_WAIT;
      end
      S_WAIT: begin
        w_miss_stall = 1'b1;
        if (i_MemRefillDone) begin
          w_state_nxt = S_RESUME;
        end
      end
      S_RESUME: begin
        // Extra cycle for the line write and re-lookup before releasing the pipe.
        w_miss_stall = 1'b1;
        w_state_nxt  = S_RUN;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase

    if (w_miss_stall) begin
      // Freeze everything; a pending branch or load-use stays in D/E and is handled after RESUME.
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
    end else begin
      w_stall_f = w_lw_stall;
      w_stall_d = w_lw_stall;
      w_flush_e = w_lw_stall | i_PCSrcE;
      w_flush_d = i_PCSrcE;
    end
  end

  // Refill wait counter and sticky timeout flag; the FSM keeps waiting after a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == S_REQ) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        if (i_MemRefillDone) begin
          r_wait_cnt <= '0;
        end else begin
          if (r_wait_cnt != CW'(TIMEOUT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
          if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
          end
        end
      end
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall_f && (r_stall_cycles != {DATA_WIDTH{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // All outputs are held at zero while reset is asserted, including the combinational ones.
  always_comb begin
    o_ForwardAE     = rst_n ? w_fwd_a   : 2'b00;
    o_ForwardBE     = rst_n ? w_fwd_b   : 2'b00;
    o_StallF        = rst_n & w_stall_f;
    o_StallD        = rst_n & w_stall_d;
    o_StallE        = rst_n & w_stall_e;
    o_StallM        = rst_n & w_stall_m;
    o_FlushD        = rst_n & w_flush_d;
    o_FlushE        = rst_n & w_flush_e;
    o_MemReq        = rst_n & w_mem_req;
    o_RefillTimeout = rst_n & r_timeout;
    o_StallCycles   = rst_n ? r_stall_cycles : '0;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control-side counterpart of the decode/execute pipeline registers. Consumes the register addresses those registers carry: Rs1D/Rs2D from decode, and Rs1E/Rs2E/RdE from execute.
- Produces the forwarding selects, and the stall/flush controls that drive the F, D, E and M pipeline registers.
- Contains a data-cache miss FSM that freezes the pipeline while a line refill completes, and counts stall cycles.

Parameters:
DATA_WIDTH, 32, width of the StallCycles counter (counter saturates, does not wrap)
TIMEOUT, 64, WAIT-state cycle count at which RefillTimeout is raised

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
Rs1D  in  5  rs1 address in decode
Rs2D  in  5  rs2 address in decode
Rs1E  in  5  rs1 address in execute
Rs2E  in  5  rs2 address in execute
RdE  in  5  destination register in execute
ResultSrcE0  in  1  execute instruction is a load
PCSrcE  in  1  branch/jump taken in execute
RdM  in  5  destination register in memory stage
RegWriteM  in  1  memory-stage instruction writes the register file
RdW  in  5  destination register in writeback
RegWriteW  in  1  writeback instruction writes the register file
CacheMissM  in  1  data-cache miss on memory-stage access
MemRefillDone  in  1  main memory has delivered the refill line (1-cycle pulse)
ForwardAE  out  2  ALU operand A select: 00 = RD1E, 10 = ALUResultM, 01 = ResultW
ForwardBE  out  2  ALU operand B select, same encoding as ForwardAE
StallF  out  1  hold PC register
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
MemReq  out  1  refill request, 1-cycle pulse
RefillTimeout  out  1  sticky error flag
StallCycles  out  DATA_WIDTH  saturating count of cycles with StallF=1

Behaviour:
- Reset:
  - rst_n low: state = RUN; wait counter, StallCycles and RefillTimeout cleared.
  - While rst_n is low, all outputs are 0.
  - Reset asserted mid-miss aborts the miss: no MemReq, no further stall.
- Forwarding (combinational, valid in every state):
  - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE = 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE = 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
- Load-use: lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: RUN, REQ, WAIT, RESUME. missStall = (state!=RUN) || (state==RUN && CacheMissM).
- RUN:
  - If CacheMissM: missStall is asserted the same cycle; next state is REQ.
  - Else: StallF = StallD = lwStall; FlushE = lwStall | PCSrcE; FlushD = PCSrcE; StallE = StallM = 0.
- REQ: MemReq=1 for exactly this cycle. Next state is RESUME if MemRefillDone is already high, else WAIT.
- WAIT:
  - MemReq=0; wait counter increments each cycle.
  - MemRefillDone → RESUME, counter cleared.
  - Counter reaching TIMEOUT sets RefillTimeout; the FSM stays in WAIT.
  - RefillTimeout clears only on reset.
- RESUME: one extra stall cycle for line write and re-lookup, then RUN.
- While missStall is asserted:
  - StallF = StallD = StallE = StallM = 1; FlushD = FlushE = 0.
  - A pending branch or load-use is held in E/D and is acted on in the first RUN cycle after RESUME.
- Back-to-back misses: CacheMissM high in the first RUN cycle after RESUME starts a new miss; there is no idle gap.
- StallCycles increments at each clock edge where StallF=1 and holds at all-ones.
- Every RdX==0 comparison is excluded from forwarding and load-use (x0 is never forwarded).

Test Plan:
- Forwarding priority: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=10. Then RegWriteM=0 → ForwardAE=01. Then Rs1E=0 → ForwardAE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1, FlushD=0. Same with RdE=0 → all 0.
- Branch: PCSrcE=1, no miss → FlushD=FlushE=1, stalls 0.
- Miss with 3-cycle refill: CacheMissM pulse in RUN; MemRefillDone 3 cycles after MemReq.
  - MemReq high exactly one cycle.
  - All four stalls high for 6 consecutive cycles (RUN-miss, REQ, 3×WAIT, RESUME).
  - StallCycles=6 afterwards.
- Simultaneous miss and branch: CacheMissM=1 and PCSrcE=1 → FlushD=FlushE=0 during the miss. Flushes assert in the first RUN cycle after RESUME.
- Timeout and reset: MemRefillDone never arrives → RefillTimeout=1 after 64 WAIT cycles, pipeline still stalled. Pulse rst_n low → all outputs 0, state RUN, flag and counter cleared.
